req_capture: RTL and testbench

Input-conditioning stage that sits directly upstream of the 4-bit priority encoder. It takes four raw, asynchronous request lines and synchronises and debounces each one. Each debounced rising edge is latched into a sticky pending bit, and the 4-bit `pending` vector drives the encoder's request input. The consumer uses the encoder's 2-bit index to clear the serviced request, which closes the loop.

---
 rtl/req_capture.sv | 107 ++++++++++
 tb/tb_req_capture.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/req_capture.sv
// Request conditioning ahead of the 4-bit priority encoder.
// Each line is synchronised, debounced, edge-detected and latched as a sticky pending bit.

module req_line #(
    parameter int DB_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic req,
    input  logic clr_hit,
    output logic pending,
    output logic overflow
);
    localparam logic [7:0] CNT_MAX = 8'(DB_CYCLES - 1);

    logic       s1, s2;
    logic       st;
    logic [7:0] cnt;
    logic       rise;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= req;
            s2 <= s1;
        end
    end

    // rise is raised on the same edge st flips 0->1, so it is a registered one-cycle flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st   <= 1'b0;
            cnt  <= '0;
            rise <= 1'b0;
        end else begin
            rise <= 1'b0;
            if (s2 == st) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                st   <= s2;
                cnt  <= '0;
                rise <= s2;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

    // A rise colliding with a clear keeps the new event pending but drops overflow,
    // since the older event is the one being serviced.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (rise)
                pending <= 1'b1;
            else if (clr_hit)
                pending <= 1'b0;

            if (rise && pending && !clr_hit)
                overflow <= 1'b1;
            else if (clr_hit)
                overflow <= 1'b0;
        end
    end
endmodule

module req_capture #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] req_in,
    input  logic       clr,
    input  logic [1:0] clr_idx,
    output logic [3:0] pending,
    output logic       any,
    output logic [3:0] overflow
);
    localparam int NUM_LANES = 4;

    logic [NUM_LANES-1:0] clr_dec;

    always_comb begin
        clr_dec = '0;
        if (clr)
            clr_dec[clr_idx] = 1'b1;
    end

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_line
        req_line #(
            .DB_CYCLES(DB_CYCLES)
        ) u_line (
            .clk     (clk),
            .reset_n (reset_n),
            .req     (req_in[i]),
            .clr_hit (clr_dec[i]),
            .pending (pending[i]),
            .overflow(overflow[i])
        );
    end

    assign any = |pending;
endmodule

// File: tb/tb_req_capture.sv
// Directed bench for req_capture with DB_CYCLES=4.
// Each scenario task drives stimulus and checks outputs inline.

module tb_req_capture;
    logic       clk;
    logic       reset_n;
    logic [3:0] req_in;
    logic       clr;
    logic [1:0] clr_idx;
    logic [3:0] pending;
    logic       any;
    logic [3:0] overflow;

    int errors = 0;
    int checks = 0;

    req_capture #(.DB_CYCLES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req_in  (req_in),
        .clr     (clr),
        .clr_idx (clr_idx),
        .pending (pending),
        .any     (any),
        .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance n rising edges, then settle 1 time unit past the edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // hold reset across two edges with req_in preset; the next edge is edge 1
    task automatic do_reset(input logic [3:0] r);
        reset_n = 1'b0;
        req_in  = r;
        clr     = 1'b0;
        clr_idx = 2'd0;
        tick(2);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        req_in  = 4'h0;
        clr     = 1'b0;
        clr_idx = 2'd0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if (pending !== 4'h0 || any !== 1'b0 || overflow !== 4'h0) begin
            errors++;
            $display("FAIL reset_state: pending=%b any=%b overflow=%b, expected 0000/0/0000", pending, any, overflow);
        end
    endtask

    task automatic test_basic_capture();
        do_reset(4'b0100);
        tick(6);
        checks++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL capture_edge6: pending=%b, expected 0000", pending);
        end
        tick(1);
        checks++;
        if (pending !== 4'b0100 || any !== 1'b1) begin
            errors++;
            $display("FAIL capture_edge7: pending=%b any=%b, expected 0100/1", pending, any);
        end
        req_in = 4'b0000;
        tick(12);
        checks++;
        if (pending !== 4'b0100 || overflow !== 4'b0000) begin
            errors++;
            $display("FAIL capture_sticky: pending=%b overflow=%b, expected 0100/0000", pending, overflow);
        end
    endtask

    task automatic test_glitch();
        do_reset(4'b0000);
        tick(4);
        req_in = 4'b0001;
        tick(3);
        req_in = 4'b0000;
        tick(12);
        checks++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL glitch_3cyc: pending=%b, expected 0000", pending);
        end
        // 4 synchronous cycles is the exact debounce threshold
        req_in = 4'b0010;
        tick(4);
        req_in = 4'b0000;
        tick(12);
        checks++;
        if (pending !== 4'b0010) begin
            errors++;
            $display("FAIL glitch_4cyc: pending=%b, expected 0010", pending);
        end
        req_in = 4'b0001;
        tick(6);
        req_in = 4'b0000;
        tick(12);
        checks++;
        if (pending !== 4'b0011) begin
            errors++;
            $display("FAIL glitch_6cyc: pending=%b, expected 0011", pending);
        end
    endtask

    task automatic test_clear_loop();
        do_reset(4'b1010);
        tick(7);
        checks++;
        if (pending !== 4'b1010) begin
            errors++;
            $display("FAIL clear_setup: pending=%b, expected 1010", pending);
        end
        req_in  = 4'b0000;
        clr     = 1'b0;
        clr_idx = 2'd3;
        tick(1);
        checks++;
        if (pending !== 4'b1010) begin
            errors++;
            $display("FAIL clear_low_ignored: pending=%b, expected 1010", pending);
        end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        checks++;
        if (pending !== 4'b0010 || any !== 1'b1) begin
            errors++;
            $display("FAIL clear_idx3: pending=%b any=%b, expected 0010/1", pending, any);
        end
        clr     = 1'b1;
        clr_idx = 2'd0;
        tick(1);
        clr = 1'b0;
        checks++;
        if (pending !== 4'b0010) begin
            errors++;
            $display("FAIL clear_zero_bit: pending=%b, expected 0010", pending);
        end
        clr     = 1'b1;
        clr_idx = 2'd1;
        tick(1);
        clr = 1'b0;
        checks++;
        if (pending !== 4'b0000 || any !== 1'b0) begin
            errors++;
            $display("FAIL clear_idx1: pending=%b any=%b, expected 0000/0", pending, any);
        end
    endtask

    task automatic test_overflow();
        do_reset(4'b0100);
        tick(7);
        req_in = 4'b0000;
        tick(6);
        req_in = 4'b0100;
        tick(6);
        checks++;
        if (overflow !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_early: overflow=%b, expected 0000", overflow);
        end
        tick(1);
        checks++;
        if (overflow !== 4'b0100 || pending !== 4'b0100) begin
            errors++;
            $display("FAIL ovf_set: overflow=%b pending=%b, expected 0100/0100", overflow, pending);
        end
        clr     = 1'b1;
        clr_idx = 2'd2;
        tick(1);
        clr = 1'b0;
        checks++;
        if (overflow !== 4'b0000 || pending !== 4'b0000) begin
            errors++;
            $display("FAIL ovf_clear: overflow=%b pending=%b, expected 0000/0000", overflow, pending);
        end
    endtask

    task automatic test_collision();
        do_reset(4'b0010);
        tick(7);
        req_in = 4'b0000;
        tick(6);
        req_in = 4'b0010;
        tick(6);
        clr     = 1'b1;
        clr_idx = 2'd1;
        tick(1);
        clr = 1'b0;
        checks++;
        if (pending !== 4'b0010 || overflow !== 4'b0000) begin
            errors++;
            $display("FAIL collision: pending=%b overflow=%b, expected 0010/0000", pending, overflow);
        end
    endtask

    task automatic test_async_reset();
        do_reset(4'hF);
        tick(7);
        checks++;
        if (pending !== 4'hF || any !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: pending=%b any=%b, expected 1111/1", pending, any);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (pending !== 4'h0 || any !== 1'b0 || overflow !== 4'h0) begin
            errors++;
            $display("FAIL areset_immediate: pending=%b any=%b overflow=%b, expected 0000/0/0000", pending, any, overflow);
        end
        #2 reset_n = 1'b1;
        tick(5);
        reset_n = 1'b0;
        #1;
        checks++;
        if (pending !== 4'h0 || any !== 1'b0) begin
            errors++;
            $display("FAIL areset_mid: pending=%b any=%b, expected 0000/0", pending, any);
        end
        #2 reset_n = 1'b1;
        tick(6);
        checks++;
        if (pending !== 4'h0) begin
            errors++;
            $display("FAIL areset_edge6: pending=%b, expected 0000", pending);
        end
        tick(1);
        checks++;
        if (pending !== 4'hF || overflow !== 4'h0) begin
            errors++;
            $display("FAIL areset_edge7: pending=%b overflow=%b, expected 1111/0000", pending, overflow);
        end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_glitch();
        test_clear_loop();
        test_overflow();
        test_collision();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete, expected finish before 100000");
        $fatal(1);
    end
endmodule
